timer_event_scheduler: RTL

//  Controller and consumer for universal_timer: drives timer start/pause/reset, walks a time-sorted event list in

---
 rtl/sched_pkg.sv | 34 +++
 rtl/sched_edge_det.sv | 22 ++
 rtl/timer_event_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared types and constants for the timer event scheduler
package sched_pkg;

  localparam int SCHED_TW = 10;
  localparam int SCHED_PW = 8;
  localparam int SCHED_AW = 8;

  // Timestamp value that terminates an event list
  localparam logic [SCHED_TW-1:0] END_MARK = '1;

  // Legacy-compatible state encodings; the enum below reuses them
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ARMED = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_WAIT  = ST_WAIT,
    S_ARMED = ST_ARMED,
    S_EMIT  = ST_EMIT,
    S_DONE  = ST_DONE
  } sched_state_e;

  // One event-list ROM word: {timestamp, payload}
  typedef struct packed {
    logic [SCHED_TW-1:0] ts;
    logic [SCHED_PW-1:0] payload;
  } sched_event_t;

endpackage

// File: rtl/sched_edge_det.sv
// rtl/sched_edge_det.sv - rising-edge detector for the level-sensitive go input
module sched_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Remember last cycle's level so a held-high go is not seen as a new start
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/timer_event_scheduler.sv
// rtl/timer_event_scheduler.sv - plays a time-sorted event list against universal_timer; SCHED_LATE_DROP_EN skips late events
module timer_event_scheduler
  import sched_pkg::*;
#(
  parameter int TW = SCHED_TW,
  parameter int PW = SCHED_PW,
  parameter int AW = SCHED_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             hold,
  output logic             tmr_start,
  output logic             tmr_pause,
  output logic             tmr_reset,
  input  logic [TW-1:0]    un_time,
  output logic [AW-1:0]    ev_addr,
  input  logic [TW+PW-1:0] ev_rdata,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [PW-1:0]    ev_payload,
  output logic             ev_late,
  output logic             done
);

  sched_state_e  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [TW-1:0] ts_q, ts_d;
  logic [PW-1:0] payload_q, payload_d;
  logic          start_q, start_d;
  logic          treset_q, treset_d;
  logic          done_q, done_d;
  logic          adv;
  logic          go_rise;
`ifndef SCHED_LATE_DROP_EN
  logic          late_q, late_d;
  logic          first_q, first_d;
`endif

  logic [TW-1:0] rd_ts;
  logic [PW-1:0] rd_payload;

  assign rd_ts      = ev_rdata[TW+PW-1:PW];
  assign rd_payload = ev_rdata[PW-1:0];

  sched_edge_det u_go_edge (
    .clk    (clk),
    .reset  (reset),
    .d_i    (go),
    .rise_o (go_rise)
  );

  // Playback sequencing: fetch, latch, wait for the timer, hand off, step
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ts_d      = ts_q;
    payload_d = payload_q;
    start_d   = 1'b0;
    treset_d  = 1'b0;
    done_d    = done_q;
    adv       = 1'b0;
`ifndef SCHED_LATE_DROP_EN
    late_d    = late_q;
    first_d   = first_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go_rise) begin
          state_d = S_FETCH;
          addr_d  = '0;
          start_d = 1'b1;
          done_d  = 1'b0;
        end else if (state_q == S_IDLE) begin
          // Keep the timer parked at zero until playback starts
          treset_d = 1'b1;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        ts_d      = rd_ts;
        payload_d = rd_payload;
        if (rd_ts == '1) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          treset_d = 1'b1;
        end else begin
          state_d = S_ARMED;
`ifndef SCHED_LATE_DROP_EN
          first_d = 1'b1;
`endif
        end
      end
      S_ARMED: begin
`ifdef SCHED_LATE_DROP_EN
        if (!hold && un_time >= ts_q) begin
          if (un_time > ts_q) begin
            adv = 1'b1;
          end else begin
            state_d = S_EMIT;
          end
        end
`else
        // Lateness is judged once, when the event is first armed
        if (first_q) begin
          late_d  = (un_time > ts_q);
          first_d = 1'b0;
        end
        if (!hold && un_time >= ts_q) begin
          state_d = S_EMIT;
        end
`endif
      end
      S_EMIT: begin
        if (ev_ready) begin
          adv = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving an entry: the last ROM address ends the list like a marker
    if (adv) begin
      if (&addr_q) begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        treset_d = 1'b1;
      end else begin
        addr_d  = addr_q + AW'(1);
        state_d = S_FETCH;
      end
    end
  end

  // State and datapath registers; reset also holds the timer in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      ts_q      <= '0;
      payload_q <= '0;
      start_q   <= 1'b0;
      treset_q  <= 1'b1;
      done_q    <= 1'b0;
`ifndef SCHED_LATE_DROP_EN
      late_q    <= 1'b0;
      first_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ts_q      <= ts_d;
      payload_q <= payload_d;
      start_q   <= start_d;
      treset_q  <= treset_d;
      done_q    <= done_d;
`ifndef SCHED_LATE_DROP_EN
      late_q    <= late_d;
      first_q   <= first_d;
`endif
    end
  end

  assign tmr_start  = start_q;
  assign tmr_reset  = treset_q;
  assign tmr_pause  = hold && (state_q != S_IDLE) && (state_q != S_DONE);
  assign ev_addr    = addr_q;
  assign ev_valid   = (state_q == S_EMIT);
  assign ev_payload = payload_q;
  assign done       = done_q;
`ifdef SCHED_LATE_DROP_EN
  assign ev_late    = 1'b0;
`else
  assign ev_late    = late_q & ev_valid;
`endif

endmodule
